// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader: length, payload, checksum into RAM from address 0.
// Holds the CPU in reset during a load and releases it only after a good checksum.
module program_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RESET_HOLD = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  byte_valid_i,
   input  logic [DATA_WIDTH-1:0] byte_data_i,
   output logic                  byte_ready_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   output logic                  cpu_reset_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_HOLD, S_DONE, S_ERROR
   } state_t;

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(2 ** ADDR_WIDTH);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

   state_t                state;
   state_t                state_nx;
   logic                  xfer;
   logic                  len_bad;
   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] sum_plus;
   logic [ADDR_WIDTH:0]   remaining;
   logic [ADDR_WIDTH-1:0] addr;
   logic [HOLD_W-1:0]     hold_cnt;

   assign xfer     = byte_valid_i & byte_ready_o;
   assign sum_plus = sum + byte_data_i;
   assign len_bad  = (byte_data_i == '0) || (byte_data_i > MAX_LEN);

   always_comb begin
      byte_ready_o = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
      busy_o       = byte_ready_o || (state == S_HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start_i) state_nx = S_LEN;
         S_LEN:  if (xfer) state_nx = len_bad ? S_ERROR : S_DATA;
         S_DATA: if (xfer && remaining == (ADDR_WIDTH+1)'(1)) state_nx = S_CSUM;
         S_CSUM: if (xfer) state_nx = (sum_plus == '0) ? S_HOLD : S_ERROR;
         S_HOLD: if (hold_cnt == '0) state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath and registered status outputs; write strobe is one cycle after its transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_data_o  <= '0;
         cpu_reset_o <= 1'b0;
         done_o      <= 1'b0;
         error_o     <= 1'b0;
         sum         <= '0;
         remaining   <= '0;
         addr        <= '0;
         hold_cnt    <= '0;
      end else begin
         ram_we_o <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  cpu_reset_o <= 1'b1;
                  done_o      <= 1'b0;
                  error_o     <= 1'b0;
                  sum         <= '0;
                  addr        <= '0;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  sum       <= byte_data_i;
                  remaining <= byte_data_i[ADDR_WIDTH:0];
                  if (len_bad) error_o <= 1'b1;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  ram_we_o   <= 1'b1;
                  ram_addr_o <= addr;
                  ram_data_o <= byte_data_i;
                  addr       <= addr + 1'b1;
                  sum        <= sum_plus;
                  remaining  <= remaining - 1'b1;
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  sum      <= sum_plus;
                  hold_cnt <= HOLD_INIT;
                  if (sum_plus != '0) error_o <= 1'b1;
               end
            end
            S_HOLD: begin
               if (hold_cnt == '0) begin
                  cpu_reset_o <= 1'b0;
                  done_o      <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader.
// A frame-position reference model is compared every cycle; literal checks pin key results.
module tb_program_loader;

   localparam int RESET_HOLD = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_i = 1'b0;
   logic       byte_valid_i = 1'b0;
   logic [7:0] byte_data_i = 8'h00;
   logic       byte_ready_o, ram_we_o, cpu_reset_o, busy_o, done_o, error_o;
   logic [3:0] ram_addr_o;
   logic [7:0] ram_data_o;

   int checks = 0;
   int failures = 0;

   program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESET_HOLD(RESET_HOLD)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .byte_valid_i(byte_valid_i),
      .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o), .ram_we_o(ram_we_o),
      .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .cpu_reset_o(cpu_reset_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM attached to the write port, plus strobe bookkeeping
   logic [7:0] dut_ram [0:15];
   int wcount = 0;
   int cyc = 0;
   int wc_hist [0:2];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we_o) begin
         dut_ram[ram_addr_o] <= ram_data_o;
         wcount <= wcount + 1;
         wc_hist[0] <= wc_hist[1];
         wc_hist[1] <= wc_hist[2];
         wc_hist[2] <= cyc;
      end
   end

   // Reference model: tracks position within the frame (0 = length, 1..n payload, n+1 checksum)
   logic       m_active = 0, m_cpu = 0, m_done = 0, m_err = 0, m_we = 0;
   int         m_k = 0, m_n = 0, m_hold = 0;
   logic [7:0] m_acc = 0, m_data = 0, m_t;
   logic [3:0] m_addr = 0;

   task automatic model_step();
      if (reset) begin
         m_active = 0; m_cpu = 0; m_done = 0; m_err = 0; m_we = 0;
         m_k = 0; m_n = 0; m_hold = 0; m_acc = 0; m_data = 0; m_addr = 0;
         return;
      end
      m_we = 0;
      if (!m_active && m_hold == 0) begin
         if (start_i) begin
            m_active = 1; m_k = 0; m_acc = 0; m_cpu = 1; m_done = 0; m_err = 0;
         end
      end else if (m_active) begin
         if (byte_valid_i) begin
            if (m_k == 0) begin
               m_n = int'(byte_data_i);
               m_acc = byte_data_i;
               if (m_n == 0 || m_n > 16) begin
                  m_active = 0; m_err = 1;
               end else m_k = 1;
            end else if (m_k <= m_n) begin
               m_we = 1;
               m_addr = 4'((m_k - 1) % 16);
               m_data = byte_data_i;
               m_acc = m_acc + byte_data_i;
               m_k++;
            end else begin
               m_active = 0;
               m_t = m_acc + byte_data_i;
               if (m_t == 8'h00) m_hold = RESET_HOLD;
               else m_err = 1;
            end
         end
      end else begin
         m_hold--;
         if (m_hold == 0) begin
            m_cpu = 0; m_done = 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("cyc_ready", byte_ready_o, m_active);
      chk("cyc_busy",  busy_o, m_active || (m_hold > 0));
      chk("cyc_cpu",   cpu_reset_o, m_cpu);
      chk("cyc_done",  done_o, m_done);
      chk("cyc_error", error_o, m_err);
      chk("cyc_we",    ram_we_o, m_we);
      chk("cyc_addr",  ram_addr_o, m_addr);
      chk("cyc_data",  ram_data_o, m_data);
   end

   logic [7:0] fr [0:19];
   int         gp [0:19];

   task automatic do_start();
      start_i = 1;
      @(negedge clk);
      start_i = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit sent = 0;
      if (gap > 0) begin
         byte_valid_i = 0;
         repeat (gap) @(negedge clk);
      end
      byte_valid_i = 1;
      byte_data_i = b;
      for (int i = 0; i < 50 && !sent; i++) begin
         if (byte_ready_o) sent = 1;
         @(negedge clk);
      end
      if (!sent) chk("send_timeout", 0, 1);
   endtask

   task automatic send_frame(input int len);
      for (int i = 0; i < len; i++) send_byte(fr[i], gp[i]);
      byte_valid_i = 0;
   endtask

   task automatic load_good3();
      fr[0] = 8'h03; fr[1] = 8'h1E; fr[2] = 8'h2F; fr[3] = 8'hF0; fr[4] = 8'hC0;
      for (int i = 0; i < 20; i++) gp[i] = 0;
   endtask

   int w0;
   logic [7:0] s;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cpu", cpu_reset_o, 0);
      chk("rst_ready", byte_ready_o, 0);
      reset = 0;
      @(negedge clk);

      // good load with exact release timing
      load_good3();
      do_start();
      w0 = wcount;
      send_frame(5);
      chk("good_cpu_e0", cpu_reset_o, 1);
      @(negedge clk);
      chk("good_cpu_e1", cpu_reset_o, 1);
      @(negedge clk);
      chk("good_cpu_e2", cpu_reset_o, 0);
      chk("good_done", done_o, 1);
      chk("good_err", error_o, 0);
      chk("good_writes", wcount - w0, 3);
      chk("good_consec", wc_hist[2] - wc_hist[0], 2);
      chk("good_ram0", dut_ram[0], 8'h1E);
      chk("good_ram1", dut_ram[1], 8'h2F);
      chk("good_ram2", dut_ram[2], 8'hF0);

      // bad checksum
      load_good3();
      fr[4] = 8'hC1;
      do_start();
      send_frame(5);
      repeat (3) @(negedge clk);
      chk("bad_err", error_o, 1);
      chk("bad_cpu", cpu_reset_o, 1);
      chk("bad_done", done_o, 0);
      chk("bad_ram2", dut_ram[2], 8'hF0);

      // length bounds
      w0 = wcount;
      fr[0] = 8'h00;
      do_start();
      send_frame(1);
      repeat (2) @(negedge clk);
      chk("len0_err", error_o, 1);
      chk("len0_writes", wcount - w0, 0);
      fr[0] = 8'h11;
      do_start();
      send_frame(1);
      repeat (2) @(negedge clk);
      chk("len17_err", error_o, 1);
      chk("len17_writes", wcount - w0, 0);

      fr[0] = 8'h10;
      s = 8'h10;
      for (int i = 1; i <= 16; i++) begin
         fr[i] = 8'(i * 7 + 3);
         s = s + fr[i];
      end
      fr[17] = 8'h00 - s;
      w0 = wcount;
      do_start();
      send_frame(18);
      repeat (4) @(negedge clk);
      chk("len16_done", done_o, 1);
      chk("len16_writes", wcount - w0, 16);
      chk("len16_ram0", dut_ram[0], 8'h0A);
      chk("len16_ramF", dut_ram[15], 8'h73);

      // stalled stream
      load_good3();
      gp[2] = 2; gp[3] = 1; gp[4] = 3;
      w0 = wcount;
      do_start();
      send_frame(5);
      repeat (4) @(negedge clk);
      chk("stall_writes", wcount - w0, 3);
      chk("stall_done", done_o, 1);
      chk("stall_ram1", dut_ram[1], 8'h2F);

      // start ignored during DATA
      w0 = wcount;
      do_start();
      send_byte(8'h03, 0);
      send_byte(8'h1E, 0);
      byte_valid_i = 0;
      do_start();
      send_byte(8'h2F, 0);
      send_byte(8'hF0, 0);
      send_byte(8'hC0, 0);
      byte_valid_i = 0;
      repeat (4) @(negedge clk);
      chk("ign_done", done_o, 1);
      chk("ign_writes", wcount - w0, 3);

      // restart from ERROR
      fr[0] = 8'h11;
      do_start();
      send_frame(1);
      @(negedge clk);
      chk("rs_err", error_o, 1);
      fr[0] = 8'h01; fr[1] = 8'hAA; fr[2] = 8'h55;
      for (int i = 0; i < 20; i++) gp[i] = 0;
      do_start();
      send_frame(3);
      repeat (4) @(negedge clk);
      chk("rs_done", done_o, 1);
      chk("rs_err_clr", error_o, 0);
      chk("rs_ram0", dut_ram[0], 8'hAA);

      // asynchronous reset mid-DATA
      do_start();
      send_byte(8'h03, 0);
      send_byte(8'h55, 0);
      byte_valid_i = 0;
      #2 reset = 1;
      #1;
      chk("arst_cpu", cpu_reset_o, 0);
      chk("arst_ready", byte_ready_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_done", done_o, 0);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      fr[0] = 8'h01; fr[1] = 8'hAA; fr[2] = 8'h55;
      do_start();
      send_frame(3);
      repeat (4) @(negedge clk);
      chk("arst_reload_done", done_o, 1);
      chk("arst_reload_ram0", dut_ram[0], 8'hAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
